// File: rtl/minus_array.sv
// Multi-lane lambda = mag - rho*phi stage for the timing/CFO estimator.
// Two-stage pipeline with frame-aligned rho, optional rounding, saturation and clip counting.
module minus_array #(
    parameter int                        NUM_CH    = 4,
    parameter int                        MAG_W     = 14,
    parameter int                        PHI_W     = 14,
    parameter int                        RHO_W     = 8,
    parameter int                        RHO_FRAC  = 7,
    parameter int                        LAMBDA_W  = 14,
    parameter logic signed [RHO_W-1:0]   RHO_RESET = 8'sh7F,
    parameter bit                        ROUND_EN  = 1'b0,
    parameter bit                        SAT_EN    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [NUM_CH*MAG_W-1:0]      mag_in,
    input  logic [NUM_CH*PHI_W-1:0]      phi_in,
    input  logic                         rho_wr_en,
    input  logic [RHO_W-1:0]             rho_wdata,
    input  logic                         sat_clr,
    output logic                         out_valid,
    output logic                         out_sof,
    output logic [NUM_CH*LAMBDA_W-1:0]   lambda_out,
    output logic [RHO_W-1:0]             rho_active,
    output logic                         sat_flag,
    output logic [15:0]                  sat_cnt
);

    localparam int PROD_W = RHO_W + PHI_W + 1;
    localparam int D_W    = ((MAG_W > PROD_W) ? MAG_W : PROD_W) + 2;
    localparam int CNT_W  = $clog2(NUM_CH + 1);

    localparam logic signed [D_W-1:0] RND_ADD = ROUND_EN ?
        ({{(D_W-1){1'b0}}, 1'b1} << (RHO_FRAC - 1)) : {D_W{1'b0}};
    localparam logic signed [D_W-1:0] LAM_MAX = {{(D_W-LAMBDA_W+1){1'b0}}, {(LAMBDA_W-1){1'b1}}};
    localparam logic signed [D_W-1:0] LAM_MIN = {{(D_W-LAMBDA_W+1){1'b1}}, {(LAMBDA_W-1){1'b0}}};

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[k]};
        end
        return c;
    endfunction

    logic                        sof_acc_s;
    logic signed [RHO_W-1:0]     rho_shadow_r, rho_active_r, rho_eff_s;
    logic signed [PROD_W-1:0]    prod_s    [NUM_CH];
    logic signed [PROD_W-1:0]    s1_prod_r [NUM_CH];
    logic signed [MAG_W-1:0]     s1_mag_r  [NUM_CH];
    logic                        s1_valid_r, s1_sof_r;
    logic signed [D_W-1:0]       shift_s   [NUM_CH];
    logic signed [D_W-1:0]       diff_s    [NUM_CH];
    logic [NUM_CH*LAMBDA_W-1:0]  lambda_s, lambda_r;
    logic [NUM_CH-1:0]           clip_s, clip_r;
    logic                        out_valid_r, out_sof_r;
    logic [15:0]                 sat_cnt_r;
    logic                        sat_flag_r;
    logic [16:0]                 sat_sum_s;
    logic [15:0]                 sat_next_s;

    assign sof_acc_s = in_valid & in_sof;

    // Select the rho for this sample: a frame start bypasses the shadow straight in
    always_comb begin
        if (sof_acc_s) begin
            rho_eff_s = rho_shadow_r;
        end else begin
            rho_eff_s = rho_active_r;
        end
    end

    // Per-lane rho*phi with phi zero-extended to keep it positive
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            prod_s[i] = PROD_W'(rho_eff_s) *
                        $signed({{(RHO_W+1){1'b0}}, phi_in[i*PHI_W +: PHI_W]});
        end
    end

    // Shadow/active rho pair; active moves only on an accepted frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rho_shadow_r <= RHO_RESET;
            rho_active_r <= RHO_RESET;
        end else begin
            if (rho_wr_en) begin
                rho_shadow_r <= rho_wdata;
            end
            if (sof_acc_s) begin
                rho_active_r <= rho_shadow_r;
            end
        end
    end

    // Stage 1: register products, mags and sideband
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_sof_r   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                s1_prod_r[i] <= {PROD_W{1'b0}};
                s1_mag_r[i]  <= {MAG_W{1'b0}};
            end
        end else begin
            s1_valid_r <= in_valid;
            s1_sof_r   <= sof_acc_s;
            if (in_valid) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    s1_prod_r[i] <= prod_s[i];
                    s1_mag_r[i]  <= mag_in[i*MAG_W +: MAG_W];
                end
            end
        end
    end

    // Stage 2 arithmetic: optional round, arithmetic shift, full-width subtract, clip or wrap
    always_comb begin
        lambda_s = {(NUM_CH*LAMBDA_W){1'b0}};
        clip_s   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            shift_s[i] = (D_W'(s1_prod_r[i]) + RND_ADD) >>> RHO_FRAC;
            diff_s[i]  = D_W'(s1_mag_r[i]) - shift_s[i];
            if (SAT_EN && (diff_s[i] > LAM_MAX)) begin
                lambda_s[i*LAMBDA_W +: LAMBDA_W] = LAM_MAX[LAMBDA_W-1:0];
                clip_s[i] = 1'b1;
            end else if (SAT_EN && (diff_s[i] < LAM_MIN)) begin
                lambda_s[i*LAMBDA_W +: LAMBDA_W] = LAM_MIN[LAMBDA_W-1:0];
                clip_s[i] = 1'b1;
            end else begin
                lambda_s[i*LAMBDA_W +: LAMBDA_W] = diff_s[i][LAMBDA_W-1:0];
            end
        end
    end

    // Stage 2 registers: data holds when idle, sideband drops to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            lambda_r    <= {(NUM_CH*LAMBDA_W){1'b0}};
            clip_r      <= {NUM_CH{1'b0}};
        end else begin
            out_valid_r <= s1_valid_r;
            out_sof_r   <= s1_sof_r;
            if (s1_valid_r) begin
                lambda_r <= lambda_s;
                clip_r   <= clip_s;
            end else begin
                clip_r   <= {NUM_CH{1'b0}};
            end
        end
    end

    // Capped accumulation of clipped lanes
    always_comb begin
        sat_sum_s = {1'b0, sat_cnt_r} + {{(17-CNT_W){1'b0}}, popcount(clip_r)};
        if (sat_sum_s[16]) begin
            sat_next_s = 16'hFFFF;
        end else begin
            sat_next_s = sat_sum_s[15:0];
        end
    end

    // Saturation counter and sticky flag; a clear beats a same-cycle clip event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt_r  <= 16'h0000;
            sat_flag_r <= 1'b0;
        end else if (sat_clr) begin
            sat_cnt_r  <= 16'h0000;
            sat_flag_r <= 1'b0;
        end else if (|clip_r) begin
            sat_cnt_r  <= sat_next_s;
            sat_flag_r <= 1'b1;
        end else begin
            sat_cnt_r  <= sat_cnt_r;
            sat_flag_r <= sat_flag_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_sof    = out_sof_r;
    assign lambda_out = lambda_r;
    assign rho_active = rho_active_r;
    assign sat_flag   = sat_flag_r;
    assign sat_cnt    = sat_cnt_r;

endmodule

// File: tb/tb_minus_array.sv
// Scoreboard bench for minus_array: one floor/saturate instance and one round/wrap instance
// share stimulus; monitors pop hand-computed expectations whenever out_valid is seen.
module tb_minus_array;

    localparam int NC = 4;
    localparam int LW = 14;

    typedef int lane4_t [4];
    typedef struct {
        logic [NC*LW-1:0] lam;
        logic             sof;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0, in_sof = 1'b0;
    logic [NC*14-1:0]  mag_in = '0, phi_in = '0;
    logic              rho_wr_en = 1'b0;
    logic [7:0]        rho_wdata = 8'h00;
    logic              sat_clr = 1'b0;

    logic              out_valid_a, out_sof_a, sat_flag_a;
    logic [NC*LW-1:0]  lam_a;
    logic [7:0]        rho_a;
    logic [15:0]       sat_cnt_a;
    logic              out_valid_b, out_sof_b, sat_flag_b;
    logic [NC*LW-1:0]  lam_b;
    logic [7:0]        rho_b;
    logic [15:0]       sat_cnt_b;

    int checks = 0;
    int failures = 0;
    exp_t exp_a[$], exp_b[$];
    exp_t ea_pop, eb_pop;
    logic [NC*LW-1:0] last_a = '0, last_b = '0;

    always #5 clk = ~clk;

    minus_array #(.ROUND_EN(1'b0), .SAT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .mag_in(mag_in), .phi_in(phi_in), .rho_wr_en(rho_wr_en), .rho_wdata(rho_wdata),
        .sat_clr(sat_clr), .out_valid(out_valid_a), .out_sof(out_sof_a), .lambda_out(lam_a),
        .rho_active(rho_a), .sat_flag(sat_flag_a), .sat_cnt(sat_cnt_a));

    minus_array #(.ROUND_EN(1'b1), .SAT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .mag_in(mag_in), .phi_in(phi_in), .rho_wr_en(rho_wr_en), .rho_wdata(rho_wdata),
        .sat_clr(sat_clr), .out_valid(out_valid_b), .out_sof(out_sof_b), .lambda_out(lam_b),
        .rho_active(rho_b), .sat_flag(sat_flag_b), .sat_cnt(sat_cnt_b));

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor for the floor/saturate instance
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (out_valid_a) begin
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL lamA_unexpected: got out_valid with lambda=%h expected no output", lam_a);
                end else begin
                    ea_pop = exp_a.pop_front();
                    if (lam_a !== ea_pop.lam || out_sof_a !== ea_pop.sof) begin
                        failures++;
                        $display("FAIL lamA: got lambda=%h sof=%b expected lambda=%h sof=%b",
                                 lam_a, out_sof_a, ea_pop.lam, ea_pop.sof);
                    end
                    last_a = ea_pop.lam;
                end
            end else if (lam_a !== last_a || out_sof_a !== 1'b0) begin
                failures++;
                $display("FAIL lamA_hold: got lambda=%h sof=%b expected lambda=%h sof=0",
                         lam_a, out_sof_a, last_a);
            end
        end
    end

    // Monitor for the round/wrap instance
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (out_valid_b) begin
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL lamB_unexpected: got out_valid with lambda=%h expected no output", lam_b);
                end else begin
                    eb_pop = exp_b.pop_front();
                    if (lam_b !== eb_pop.lam || out_sof_b !== eb_pop.sof) begin
                        failures++;
                        $display("FAIL lamB: got lambda=%h sof=%b expected lambda=%h sof=%b",
                                 lam_b, out_sof_b, eb_pop.lam, eb_pop.sof);
                    end
                    last_b = eb_pop.lam;
                end
            end else if (lam_b !== last_b || out_sof_b !== 1'b0) begin
                failures++;
                $display("FAIL lamB_hold: got lambda=%h sof=%b expected lambda=%h sof=0",
                         lam_b, out_sof_b, last_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lanes(input lane4_t mg, input lane4_t ph);
        for (int i = 0; i < NC; i++) begin
            mag_in[i*14 +: 14] = 14'(mg[i]);
            phi_in[i*14 +: 14] = 14'(ph[i]);
        end
    endtask

    task automatic send(input bit sof, input lane4_t mg, input lane4_t ph,
                        input lane4_t ea, input lane4_t eb, input bit wr, input int wd);
        exp_t xa, xb;
        drive_lanes(mg, ph);
        for (int i = 0; i < NC; i++) begin
            xa.lam[i*LW +: LW] = LW'(ea[i]);
            xb.lam[i*LW +: LW] = LW'(eb[i]);
        end
        xa.sof = sof;
        xb.sof = sof;
        exp_a.push_back(xa);
        exp_b.push_back(xb);
        in_valid  = 1'b1;
        in_sof    = sof;
        rho_wr_en = wr;
        rho_wdata = 8'(wd);
        step();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        rho_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_rho(input int v);
        rho_wr_en = 1'b1;
        rho_wdata = 8'(v);
        step();
        rho_wr_en = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b1;
        step();
        check("reset_out_valid", out_valid_a, 0);
        check("reset_lambda", lam_a, 0);
        check("reset_rho_active", rho_a, 8'h7F);
        check("reset_sat_cnt", sat_cnt_a, 0);

        // Default rho, then a full-scale clip
        send(1'b1, '{1000,1000,1000,1000}, '{512,512,512,512},
             '{492,492,492,492}, '{492,492,492,492}, 1'b0, 0);
        send(1'b0, '{-8192,-8192,-8192,-8192}, '{16383,16383,16383,16383},
             '{-8192,-8192,-8192,-8192}, '{-8063,-8063,-8063,-8063}, 1'b0, 0);
        idle(4);
        check("satA_cnt_full", sat_cnt_a, 4);
        check("satA_flag_full", sat_flag_a, 1);
        check("satB_cnt_wrap", sat_cnt_b, 0);
        check("satB_flag_wrap", sat_flag_b, 0);
        check("rho_default", rho_a, 8'h7F);

        // Rounding and negative rho
        wr_rho(8'h01);
        send(1'b1, '{0,0,0,0}, '{64,64,64,64}, '{0,0,0,0}, '{-1,-1,-1,-1}, 1'b0, 0);
        check("rho_bypass_01", rho_a, 8'h01);
        idle(3);
        wr_rho(8'h80);
        send(1'b1, '{0,0,0,0}, '{100,100,100,100}, '{100,100,100,100}, '{100,100,100,100}, 1'b0, 0);
        idle(3);

        // Mid-frame write is deferred; write on a sof lands one frame later
        wr_rho(8'h7F);
        send(1'b1, '{0,0,0,0}, '{1000,1000,1000,1000}, '{-992,-992,-992,-992}, '{-992,-992,-992,-992}, 1'b0, 0);
        send(1'b0, '{0,0,0,0}, '{1000,1000,1000,1000}, '{-992,-992,-992,-992}, '{-992,-992,-992,-992}, 1'b1, 8'h40);
        send(1'b0, '{0,0,0,0}, '{1000,1000,1000,1000}, '{-992,-992,-992,-992}, '{-992,-992,-992,-992}, 1'b0, 0);
        check("rho_midframe", rho_a, 8'h7F);
        send(1'b1, '{0,0,0,0}, '{1000,1000,1000,1000}, '{-500,-500,-500,-500}, '{-500,-500,-500,-500}, 1'b0, 0);
        check("rho_next_frame", rho_a, 8'h40);
        send(1'b1, '{0,0,0,0}, '{1000,1000,1000,1000}, '{-500,-500,-500,-500}, '{-500,-500,-500,-500}, 1'b1, 8'h20);
        check("rho_wr_on_sof_old", rho_a, 8'h40);
        send(1'b1, '{0,0,0,0}, '{1000,1000,1000,1000}, '{-250,-250,-250,-250}, '{-250,-250,-250,-250}, 1'b0, 0);
        check("rho_wr_on_sof_new", rho_b, 8'h20);

        // Distinct lanes with idle gaps (rho = 0x20)
        send(1'b0, '{10,20,30,40}, '{4,8,12,16}, '{9,18,27,36}, '{9,18,27,36}, 1'b0, 0);
        idle(1);
        send(1'b0, '{-100,-200,300,400}, '{40,80,120,160}, '{-110,-220,270,360}, '{-110,-220,270,360}, 1'b0, 0);
        send(1'b0, '{1,2,3,4}, '{0,0,0,2}, '{1,2,3,4}, '{1,2,3,3}, 1'b0, 0);
        idle(2);
        send(1'b1, '{5,-5,7,-7}, '{4,4,4,4}, '{4,-6,6,-8}, '{4,-6,6,-8}, 1'b0, 0);
        idle(3);

        // Clear, partial clip, then clear racing a clip event
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("satA_cnt_clr", sat_cnt_a, 0);
        check("satA_flag_clr", sat_flag_a, 0);
        send(1'b0, '{-8192,-8000,8191,0}, '{16383,800,0,0},
             '{-8192,-8192,8191,0}, '{4096,8184,8191,0}, 1'b0, 0);
        idle(4);
        check("satA_cnt_partial", sat_cnt_a, 2);
        check("satA_flag_partial", sat_flag_a, 1);
        check("satB_cnt_partial", sat_cnt_b, 0);
        send(1'b0, '{-8192,-8192,-8192,-8192}, '{16383,16383,16383,16383},
             '{-8192,-8192,-8192,-8192}, '{4096,4096,4096,4096}, 1'b0, 0);
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        idle(2);
        check("satA_cnt_clr_wins", sat_cnt_a, 0);
        check("satA_flag_clr_wins", sat_flag_a, 0);

        // Reset with two samples in flight; neither may emerge
        drive_lanes('{300,300,300,300}, '{8,8,8,8});
        in_valid = 1'b1;
        in_sof   = 1'b1;
        rho_wr_en = 1'b1;
        rho_wdata = 8'h10;
        step();
        in_sof    = 1'b0;
        rho_wr_en = 1'b0;
        step();
        in_valid = 1'b0;
        #1 rst = 1'b0;
        last_a = '0;
        last_b = '0;
        exp_a.delete();
        exp_b.delete();
        #1;
        check("rst_async_out_valid", out_valid_a, 0);
        check("rst_async_lambda", lam_b, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        step();
        idle(3);
        check("post_rst_out_valid", out_valid_a, 0);
        check("post_rst_rho", rho_a, 8'h7F);
        check("post_rst_sat_cnt", sat_cnt_a, 0);
        check("post_rst_lambda", lam_a, 0);
        send(1'b1, '{1000,1000,1000,1000}, '{512,512,512,512},
             '{492,492,492,492}, '{492,492,492,492}, 1'b0, 0);
        idle(4);
        check("drainA", exp_a.size(), 0);
        check("drainB", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
